lc3_inst_mem: RTL
=================

# lc3_inst_mem

Instruction memory for the LC3 core, sitting between the testbench load port (`write_inst`/`addr_inst`/`din_inst`) and the core's fetch stage (`rd_fetch`/`pc_fetch`). It stores instruction words written by the bench into a fixed address window and returns them to fetch with a registered one-cycle latency. Fetches of out-of-window or never-written locations are flagged, and a distinct-word counter reports load progress.

## Interface
- `ADDR_W`, 8: word-address width; depth = 2**ADDR_W words.
- `BASE_ADDR`, 16'h3000: first LC3 address of the window. Must be aligned to the depth.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `write_inst` input 1: load strobe.
- `addr_inst` input 16: load address (LC3 address space).
- `din_inst` input 16: load data.
- `rd_fetch` input 1: fetch request.
- `pc_fetch` input 16: fetch address.
- `instrmem_dout` output 16: fetched instruction.
- `inst_valid` output 1: one-cycle pulse when `instrmem_dout` is updated by a fetch.
- `fetch_err` output 1: one-cycle pulse alongside `inst_valid` for an out-of-window or unwritten fetch.
- `wr_err` output 1: one-cycle pulse for an out-of-window load.
- `loaded_count` output ADDR_W+1: number of distinct words written since reset.

## Operation
- In-window test: `addr - BASE_ADDR < 2**ADDR_W`, using 16-bit unsigned arithmetic. Offset = `addr - BASE_ADDR` truncated to ADDR_W bits.
- Load in window: write `din_inst` to the array at the offset and set that word's valid bit.
  - If the valid bit was clear, increment `loaded_count`. It cannot exceed 2**ADDR_W.
  - Rewriting an address updates the data only; the count is unchanged.
- Load out of window: array, valid bits and count are unchanged; `wr_err` pulses the next cycle.
- Fetch in window with the valid bit set: return the stored word.
- Fetch out of window or with the valid bit clear: return `LC3_NOP` (16'h0000, BR-never) with `fetch_err`.
- Per-word state is UNWRITTEN→WRITTEN. The only way back to UNWRITTEN is reset.
- Reset:
  - Clears all valid bits, `loaded_count`=0, `instrmem_dout`=16'h0000, and `inst_valid`, `fetch_err`, `wr_err`=0.
  - Array contents are not reset.
  - A reset asserted mid-stream discards any in-flight fetch; no `inst_valid` follows.

## Timing
- Fetch latency is 1 cycle. `rd_fetch` sampled high at edge N produces `instrmem_dout`, `inst_valid=1` and `fetch_err` at edge N+1, held until edge N+2.
- Back-to-back fetches every cycle are supported; throughput is 1 word/cycle.
- When `rd_fetch` is low, `instrmem_dout` holds its last value and `inst_valid`=0.
- A load takes effect at edge N; a fetch of that word sampled at edge N+1 or later returns the new data.
- Same-cycle load and fetch to the same in-window address: behaviour is set by the macro below.
- A same-cycle load and fetch to different addresses are independent.
- `loaded_count` updates at the edge following the load. `wr_err` is registered with 1-cycle latency.

## Configuration
- Macro `LC3_IMEM_BYPASS_EN`.
- Defined: same-cycle same-address load and fetch forwards `din_inst` (write-through). `fetch_err` is 0 even if the word was previously unwritten.
- Undefined: read-before-write. The fetch returns the old word, or `LC3_NOP` with `fetch_err` if the word was unwritten; the new data is visible from the next fetch.

## Structure
- Package `lc3_pkg`: `typedef logic [15:0] lc3_word_t`; constants `LC3_NOP` = 16'h0000 and `LC3_IMEM_BASE` = 16'h3000, used as the `BASE_ADDR` default.
- Sub-module `lc3_imem_ram`: one synchronous write port and one synchronous read port, no reset, read-before-write. Window decode, valid bits, counter, bypass mux and error logic live in the top.

## Test plan
- After reset, fetch 16'h3000: `instrmem_dout`=16'h0000, `inst_valid`=1, `fetch_err`=1 one cycle later; `loaded_count`=0.
- Load 16'h1261 at 16'h3000 and 16'h5020 at 16'h3001, then fetch 16'h3000 and 16'h3001 on consecutive cycles: 16'h1261 then 16'h5020 on consecutive cycles, no `fetch_err`; `loaded_count`=2.
- Load 16'hABCD at 16'h3000 again: `loaded_count` stays 2; the next fetch returns 16'hABCD.
- Load at 16'h2FFF and at 16'h3100 (DEPTH=256): `wr_err` pulses each time; `loaded_count` unchanged. Fetch 16'h3100: `fetch_err`=1, data 16'h0000.
- Same-cycle load 16'h0E05 and fetch at 16'h3005, word unwritten:
  - With macro: returns 16'h0E05, `fetch_err`=0.
  - Without macro: returns 16'h0000, `fetch_err`=1; a second fetch returns 16'h0E05.
- Assert `reset` asynchronously in the cycle after `rd_fetch`: no `inst_valid`, `loaded_count`=0; a fetch of 16'h3000 afterwards flags `fetch_err`.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 types and constants for the instruction memory.
package lc3_pkg;

  typedef logic [15:0] lc3_word_t;

  // BR with no condition bits set: never branches, used as the fetch filler.
  localparam lc3_word_t LC3_NOP       = 16'h0000;
  localparam lc3_word_t LC3_IMEM_BASE = 16'h3000;

  // Source of the fetched word presented on instrmem_dout.
  typedef enum logic [1:0] {
    SEL_NOP = 2'd0,
    SEL_RAM = 2'd1,
    SEL_BYP = 2'd2
  } dout_sel_e;

endpackage

// File: rtl/lc3_inst_mem_if.sv
// Load/fetch bus between the bench/core (master) and the instruction memory (slave).
interface lc3_inst_mem_if
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic        write_inst;
  lc3_word_t   addr_inst;
  lc3_word_t   din_inst;
  logic        rd_fetch;
  lc3_word_t   pc_fetch;
  lc3_word_t   instrmem_dout;
  logic        inst_valid;
  logic        fetch_err;
  logic        wr_err;
  logic [ADDR_W:0] loaded_count;

  modport master (
    output write_inst, addr_inst, din_inst, rd_fetch, pc_fetch,
    input  instrmem_dout, inst_valid, fetch_err, wr_err, loaded_count
  );

  modport slave (
    input  write_inst, addr_inst, din_inst, rd_fetch, pc_fetch,
    output instrmem_dout, inst_valid, fetch_err, wr_err, loaded_count
  );

endinterface

// File: rtl/lc3_imem_ram.sv
// Simple dual-port RAM: one synchronous write, one registered read, read-before-write, no reset.
module lc3_imem_ram
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  lc3_word_t         wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output lc3_word_t         rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  lc3_word_t mem [DEPTH];

  // Write port; read port holds its last word while re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lc3_inst_mem.sv
// LC3 instruction memory: windowed load port, 1-cycle fetch, per-word valid tracking.
// Optional macro LC3_IMEM_BYPASS_EN: forward same-cycle same-address load data to fetch.
module lc3_inst_mem
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter lc3_word_t   BASE_ADDR = LC3_IMEM_BASE
) (
  input  logic           clk,
  input  logic           reset,
  lc3_inst_mem_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  lc3_word_t         w_off, f_off, ram_rdata;
  logic              w_in_win, f_in_win, wr_en, f_hit, same_addr;
  logic [ADDR_W-1:0] w_idx, f_idx;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W:0]   count_q;
  logic              inst_valid_q, fetch_err_q, wr_err_q, err_d;
  dout_sel_e         sel_q, sel_d;
  lc3_word_t         dout_c;

  // Window decode for both ports using 16-bit wrap-around arithmetic.
  always_comb begin
    w_off     = bus.addr_inst - BASE_ADDR;
    f_off     = bus.pc_fetch - BASE_ADDR;
    w_in_win  = {1'b0, w_off} < 17'(DEPTH);
    f_in_win  = {1'b0, f_off} < 17'(DEPTH);
    w_idx     = w_off[ADDR_W-1:0];
    f_idx     = f_off[ADDR_W-1:0];
    wr_en     = bus.write_inst && w_in_win;
    f_hit     = f_in_win && valid_q[f_idx];
    same_addr = wr_en && f_in_win && (w_idx == f_idx);
  end

  // Choose the source of the next fetched word and whether it is an error.
  always_comb begin
    sel_d = SEL_NOP;
    err_d = 1'b1;
    if (f_hit) begin
      sel_d = SEL_RAM;
      err_d = 1'b0;
    end
`ifdef LC3_IMEM_BYPASS_EN
    if (same_addr) begin
      sel_d = SEL_BYP;
      err_d = 1'b0;
    end
`endif
  end

  lc3_imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (w_idx),
    .wdata (bus.din_inst),
    .re    (bus.rd_fetch),
    .raddr (f_idx),
    .rdata (ram_rdata)
  );

  // Valid bits, load counter and fetch/load status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      sel_q        <= SEL_NOP;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      inst_valid_q <= bus.rd_fetch;
      fetch_err_q  <= bus.rd_fetch && err_d;
      wr_err_q     <= bus.write_inst && !w_in_win;
      if (bus.rd_fetch) sel_q <= sel_d;
      if (wr_en) begin
        valid_q[w_idx] <= 1'b1;
        if (!valid_q[w_idx]) count_q <= count_q + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef LC3_IMEM_BYPASS_EN
  lc3_word_t byp_q;

  // Capture load data for a same-cycle forwarded fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             byp_q <= LC3_NOP;
    else if (bus.rd_fetch && same_addr)    byp_q <= bus.din_inst;
  end
`endif

  // Fetched word comes straight from a registered source.
  always_comb begin
    dout_c = LC3_NOP;
    case (sel_q)
      SEL_RAM: dout_c = ram_rdata;
`ifdef LC3_IMEM_BYPASS_EN
      SEL_BYP: dout_c = byp_q;
`endif
      default: dout_c = LC3_NOP;
    endcase
  end

  assign bus.instrmem_dout = dout_c;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.fetch_err     = fetch_err_q;
  assign bus.wr_err        = wr_err_q;
  assign bus.loaded_count  = count_q;

endmodule
